// File: rtl/gecko_reg_status_tracker.sv
// Per-register outstanding-write scoreboard: decode reserves rd on issue, writeback releases it,
// and a drain FSM can hold off issue until every outstanding write has retired.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal operation, issue allowed when rd is not FULL
// ST_DRAIN | issue blocked, waiting for outstanding_count to reach 0
// ST_DONE  | issue blocked, no writes outstanding, drain_done asserted
module gecko_reg_status_tracker #(
    parameter int  NUM_REGS      = 32,
    parameter int  COUNTER_WIDTH = 2,
    localparam int ADDR_W        = $clog2(NUM_REGS),
    localparam int OC_W          = $clog2((NUM_REGS - 1) * ((1 << COUNTER_WIDTH) - 1) + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [ADDR_W-1:0]        issue_reg_addr,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [ADDR_W-1:0]        wb_reg_addr,
    input  logic [ADDR_W-1:0]        rd_addr,
    input  logic [ADDR_W-1:0]        rs1_addr,
    input  logic [ADDR_W-1:0]        rs2_addr,
    output logic [COUNTER_WIDTH-1:0] rd_status,
    output logic [COUNTER_WIDTH-1:0] rs1_status,
    output logic [COUNTER_WIDTH-1:0] rs2_status,
    input  logic                     drain_req,
    output logic                     drain_done,
    output logic [OC_W-1:0]          outstanding_count,
    output logic                     underflow_error
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] CNT_FULL = '1;
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);
    localparam logic [OC_W-1:0]          OC_ONE   = OC_W'(1);

    state_t                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] cnt_q [NUM_REGS];
    logic [COUNTER_WIDTH-1:0] cnt_d [NUM_REGS];
    logic [OC_W-1:0]          oc_q, oc_d;
    logic                     uf_q, uf_d;

    logic issue_fire;
    logic issue_hit;
    logic wb_hit;
    logic same_reg;
    logic wb_under;
    logic wb_dec;
    logic oc_inc;

    always_comb begin
        issue_ready = (state_q == ST_RUN) &&
                      ((issue_reg_addr == '0) || (cnt_q[issue_reg_addr] != CNT_FULL));
        wb_ready    = 1'b1;
        issue_fire  = issue_valid && issue_ready;
        issue_hit   = issue_fire && (issue_reg_addr != '0);
        wb_hit      = wb_valid && (wb_reg_addr != '0);
        same_reg    = issue_hit && wb_hit && (issue_reg_addr == wb_reg_addr);
        // Underflow is judged on the pre-update count, even when an issue to the same reg fires.
        wb_under    = wb_hit && (cnt_q[wb_reg_addr] == '0);
        wb_dec      = wb_hit && !wb_under && !same_reg;
        oc_inc      = issue_hit && !same_reg;
        uf_d        = uf_q || wb_under;
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        cnt_d[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (oc_inc && (issue_reg_addr == ADDR_W'(i))) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
            if (wb_dec && (wb_reg_addr == ADDR_W'(i))) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end
    end

    // Kept equal to the sum of all counters, so it can never wrap.
    always_comb begin
        oc_d = oc_q;
        case ({oc_inc, wb_dec})
            2'b10:   oc_d = oc_q + OC_ONE;
            2'b01:   oc_d = oc_q - OC_ONE;
            default: oc_d = oc_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (drain_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!drain_req)        state_d = ST_RUN;
                else if (oc_q == '0)   state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!drain_req) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            oc_q    <= '0;
            uf_q    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            oc_q    <= oc_d;
            uf_q    <= uf_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        rd_status         = (rd_addr  == '0) ? '0 : cnt_q[rd_addr];
        rs1_status        = (rs1_addr == '0) ? '0 : cnt_q[rs1_addr];
        rs2_status        = (rs2_addr == '0) ? '0 : cnt_q[rs2_addr];
        drain_done        = (state_q == ST_DONE);
        outstanding_count = oc_q;
        underflow_error   = uf_q;
    end

endmodule

// File: tb/tb_gecko_reg_status_tracker.sv
// Scoreboard bench for gecko_reg_status_tracker: a behavioural model queues expected
// post-edge state per driven cycle, which is popped and compared after the clock edge.
module tb_gecko_reg_status_tracker;

    localparam int NR = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid, issue_ready, wb_valid, wb_ready, drain_req, drain_done;
    logic [4:0] issue_reg_addr, wb_reg_addr, rd_addr, rs1_addr, rs2_addr;
    logic [1:0] rd_status, rs1_status, rs2_status;
    logic [6:0] outstanding_count;
    logic       underflow_error;

    gecko_reg_status_tracker dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_reg_addr(issue_reg_addr),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg_addr(wb_reg_addr),
        .rd_addr(rd_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_status(rd_status), .rs1_status(rs1_status), .rs2_status(rs2_status),
        .drain_req(drain_req), .drain_done(drain_done),
        .outstanding_count(outstanding_count), .underflow_error(underflow_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st_rd, st_rs1, st_rs2;
        int oc, uf, done;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // reference model: per-reg counts, FSM (0 RUN, 1 DRAIN, 2 DONE), sticky error
    int mc[NR];
    int moc;
    int mst;
    int muf;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mc[i] = 0;
        moc = 0;
        mst = 0;
        muf = 0;
    endtask

    task automatic step(input bit iv, input int ia, input bit wv, input int wa,
                        input bit dr, input int watch);
        int   rdy, nst, sum;
        bit   ifire, whit;
        exp_t e;
        @(negedge clk);
        issue_valid    = iv;
        issue_reg_addr = ia[4:0];
        wb_valid       = wv;
        wb_reg_addr    = wa[4:0];
        drain_req      = dr;
        rd_addr        = watch[4:0];
        rs1_addr       = ia[4:0];
        rs2_addr       = wa[4:0];
        #1;
        rdy = (mst == 0 && (ia == 0 || mc[ia] != 3)) ? 1 : 0;
        check_eq("issue_ready", {31'd0, issue_ready}, rdy);
        check_eq("wb_ready", {31'd0, wb_ready}, 1);

        case (mst)
            0:       nst = dr ? 1 : 0;
            1:       nst = !dr ? 0 : (moc == 0 ? 2 : 1);
            default: nst = dr ? 2 : 0;
        endcase
        ifire = iv && (rdy == 1) && (ia != 0);
        whit  = wv && (wa != 0);
        if (ifire && whit && ia == wa) begin
            if (mc[wa] == 0) muf = 1;
        end else begin
            if (ifire) mc[ia]++;
            if (whit) begin
                if (mc[wa] == 0) muf = 1;
                else             mc[wa]--;
            end
        end
        sum = 0;
        for (int i = 1; i < NR; i++) sum += mc[i];
        moc = sum;
        mst = nst;

        e.st_rd  = mc[watch];
        e.st_rs1 = mc[ia];
        e.st_rs2 = mc[wa];
        e.oc     = moc;
        e.uf     = muf;
        e.done   = (mst == 2) ? 1 : 0;
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq("rd_status", {30'd0, rd_status}, e.st_rd);
        check_eq("rs1_status", {30'd0, rs1_status}, e.st_rs1);
        check_eq("rs2_status", {30'd0, rs2_status}, e.st_rs2);
        check_eq("outstanding_count", {25'd0, outstanding_count}, e.oc);
        check_eq("underflow_error", {31'd0, underflow_error}, e.uf);
        check_eq("drain_done", {31'd0, drain_done}, e.done);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        drain_req = 1'b0;
        issue_valid = 1'b0;
        wb_valid = 1'b0;
        #1;
        model_reset();
        check_eq("rst_outstanding", {25'd0, outstanding_count}, 0);
        check_eq("rst_underflow", {31'd0, underflow_error}, 0);
        check_eq("rst_drain_done", {31'd0, drain_done}, 0);
        check_eq("rst_rd_status", {30'd0, rd_status}, 0);
        check_eq("rst_rs1_status", {30'd0, rs1_status}, 0);
        check_eq("rst_issue_ready", {31'd0, issue_ready}, 1);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bit rdr;
        rst            = 1'b0;
        issue_valid    = 1'b0;
        wb_valid       = 1'b0;
        drain_req      = 1'b0;
        issue_reg_addr = 5'd0;
        wb_reg_addr    = 5'd0;
        rd_addr        = 5'd5;
        rs1_addr       = 5'd7;
        rs2_addr       = 5'd9;
        model_reset();
        apply_reset();

        // single issue / writeback
        step(1, 5, 0, 0, 0, 5);
        step(0, 0, 1, 5, 0, 5);

        // fill x7 to FULL; x7 blocked, x8 not
        repeat (3) step(1, 7, 0, 0, 0, 7);
        step(0, 7, 0, 0, 0, 7);
        step(0, 8, 0, 0, 0, 7);

        // FULL x7: issue blocked, wb still retires
        step(1, 7, 1, 7, 0, 7);

        // x9 at 1: issue + wb same reg
        step(1, 9, 0, 0, 0, 9);
        step(1, 9, 1, 9, 0, 9);

        // x0 never tracked; wb to empty x3 flags underflow
        step(1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 3, 0, 3);

        // clear pending x7 (2) and x9 (1)
        step(0, 0, 1, 7, 0, 7);
        step(0, 0, 1, 7, 0, 7);
        step(0, 0, 1, 9, 0, 9);

        // drain: x4=2, x6=1, last x4 issue coincides with drain_req rising
        step(1, 4, 0, 0, 0, 4);
        step(1, 6, 0, 0, 0, 6);
        step(1, 4, 0, 0, 1, 4);
        step(1, 8, 0, 0, 1, 8);
        step(0, 0, 1, 4, 1, 4);
        step(0, 0, 1, 4, 1, 4);
        step(0, 0, 1, 6, 1, 6);
        step(1, 5, 0, 0, 1, 5);
        step(1, 5, 0, 0, 1, 5);
        step(1, 5, 0, 0, 0, 5);
        step(1, 5, 0, 0, 0, 5);

        // randomised traffic with occasional drain requests
        rdr = 0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) rdr = !rdr;
            step($urandom_range(0, 1) == 1, $urandom_range(0, 7),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7), rdr,
                 $urandom_range(0, 7));
        end

        // reset in the middle of a drain
        apply_reset();
        step(1, 5, 0, 0, 0, 5);
        step(1, 6, 0, 0, 1, 5);
        step(0, 0, 0, 0, 1, 5);
        @(negedge clk);
        rst = 1'b0;
        rd_addr = 5'd5;
        #1;
        model_reset();
        check_eq("midrst_outstanding", {25'd0, outstanding_count}, 0);
        check_eq("midrst_status_x5", {30'd0, rd_status}, 0);
        check_eq("midrst_drain_done", {31'd0, drain_done}, 0);
        @(negedge clk);
        rst = 1'b1;
        drain_req = 1'b0;
        step(1, 5, 0, 0, 0, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
